// File: rtl/pc_unit_if.sv
// Bundle that connects the fetch PC unit to next-PC select logic and instruction memory.
// The master drives redirect, exception and stall requests.
// The slave (pc_unit) returns the PC state.
// All addresses are word addresses [AW-1:2].
interface pc_unit_if #(
  parameter int AW = 32
);
  logic          Stall;
  logic          BrValid;
  logic [AW-1:2] BrTarget;
  logic          Exc;
  logic [AW-1:2] ExcPC;
  logic          Eret;
  logic [AW-1:2] PC;
  logic [AW-1:2] PCPlus4;
  logic [AW-1:2] EPC;
  logic          Pending;
  logic          BadFetch;

  modport master (
    output Stall, BrValid, BrTarget, Exc, ExcPC, Eret,
    input  PC, PCPlus4, EPC, Pending, BadFetch
  );

  modport slave (
    input  Stall, BrValid, BrTarget, Exc, ExcPC, Eret,
    output PC, PCPlus4, EPC, Pending, BadFetch
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with stall, redirect buffering, exception entry/EPC and ERET.
// Optional feature: define PC_BOUNDS_CHECK_EN to trap fetches outside the legal
// instruction window [IMEM_BASE, IMEM_BASE + 4*IMEM_WORDS).
// A trapped fetch goes to EXC_VEC, the offending address is saved in EPC, and BadFetch pulses.
module pc_unit #(
  parameter int            AW         = 32,
  parameter logic [AW-1:0] RESET_VEC  = 32'h0000_3000,
  parameter logic [AW-1:0] EXC_VEC    = 32'h0000_4180,
  parameter logic [AW-1:0] IMEM_BASE  = 32'h0000_3000,
  parameter int            IMEM_WORDS = 1024
) (
  input  logic      Clk,
  input  logic      Reset,
  pc_unit_if.slave  bus
);

`ifdef PC_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHECK = 1'b1;
`else
  localparam bit BOUNDS_CHECK = 1'b0;
`endif

  localparam logic [AW-1:2] RESET_W = RESET_VEC[AW-1:2];
  localparam logic [AW-1:2] EXC_W   = EXC_VEC[AW-1:2];
  localparam logic [AW-1:2] ONE_W   = (AW-2)'(1);

  // Window bounds in the word domain, one bit wider so the upper bound cannot overflow.
  localparam logic [AW-2:0] WIN_LO = {1'b0, IMEM_BASE[AW-1:2]};
  localparam logic [AW-2:0] WIN_HI = WIN_LO + (AW-1)'(IMEM_WORDS);

  // Redirect buffer occupancy: HELD means a redirect arrived while stalled.
  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } pend_state_t;

  pend_state_t   state_q;
  logic [AW-1:2] pc_q;
  logic [AW-1:2] epc_q;
  logic [AW-1:2] pend_tgt_q;
  logic          bad_fetch_q;

  logic [AW-1:2] pc_plus1;
  logic [AW-1:2] pc_d;
  logic          out_of_window;
  logic          trap_d;

  assign pc_plus1 = pc_q + ONE_W;

  // Candidate PC for an unstalled cycle: a live redirect beats a buffered one, which beats sequential fetch.
  // Exception and ERET targets never pass through this path, so they are never bounds-checked.
  always_comb begin
    pc_d = pc_plus1;
    if (bus.BrValid) begin
      pc_d = bus.BrTarget;
    end else if (state_q == HELD) begin
      pc_d = pend_tgt_q;
    end
    out_of_window = ({1'b0, pc_d} < WIN_LO) || ({1'b0, pc_d} >= WIN_HI);
    trap_d        = BOUNDS_CHECK && out_of_window;
  end

  // PC/EPC/buffer update, in priority order: Reset, Exc, Eret, Stall, then the candidate path.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q        <= RESET_W;
      epc_q       <= '0;
      pend_tgt_q  <= '0;
      state_q     <= IDLE;
      bad_fetch_q <= 1'b0;
    end else begin
      bad_fetch_q <= 1'b0;
      if (bus.Exc) begin
        pc_q    <= EXC_W;
        epc_q   <= bus.ExcPC;
        state_q <= IDLE;
      end else if (bus.Eret) begin
        pc_q    <= epc_q;
        state_q <= IDLE;
      end else if (bus.Stall) begin
        // A later redirect during the same stall overwrites an earlier one.
        if (bus.BrValid) begin
          pend_tgt_q <= bus.BrTarget;
          state_q    <= HELD;
        end
      end else begin
        state_q <= IDLE;
        if (trap_d) begin
          pc_q        <= EXC_W;
          epc_q       <= pc_d;
          bad_fetch_q <= 1'b1;
        end else begin
          pc_q <= pc_d;
        end
      end
    end
  end

  assign bus.PC       = pc_q;
  assign bus.PCPlus4  = pc_plus1;
  assign bus.EPC      = epc_q;
  assign bus.Pending  = (state_q == HELD);
  assign bus.BadFetch = bad_fetch_q;

endmodule
